// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Shares one single-port SRAM between the IF-stage fetch requester
//            and the MEM-stage load/store requester.
//            - Each access is a multi-cycle sequence: IDLE -> ACCESS -> RESP.
//            - When both requesters are pending, grants alternate between them.
//            - Drives the pipeline stall signals while a request is outstanding.
// Ports    : clk, reset (async, active-low)
//            inst_req/inst_addr   -> inst_rdata/inst_ready   fetch side
//            data_req/data_we/data_addr/data_wdata
//                                 -> data_rdata/data_ready   load/store side
//            sram_cs/sram_we/sram_addr/sram_wdata (registered), sram_rdata
//            stall_if, stall_mem  combinational stall outputs
// Revision : 1.0  initial release
// ============================================================================
module sram_port_arbiter #(
   parameter int ADDR_W        = 11,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inst_req,
   input  logic [31:0]       inst_addr,
   output logic [31:0]       inst_rdata,
   output logic              inst_ready,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [31:0]       data_addr,
   input  logic [31:0]       data_wdata,
   output logic [31:0]       data_rdata,
   output logic              data_ready,
   output logic              sram_cs,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

   state_t            state;
   state_t            next_state;
   logic [3:0]        counter;
   logic              owner;       // 1 = data requester, 0 = fetch
   logic              last_grant;  // 1 = data requester, 0 = fetch
   logic              grant_valid;
   logic              grant_data;
   logic              access_done;
   logic [ADDR_W-1:0] grant_addr;
   logic              unused_addr_bits;

   // Byte-offset bits and bits above the SRAM word range are deliberately dropped.
   assign unused_addr_bits = ^{inst_addr[31:ADDR_W+2], inst_addr[1:0],
                               data_addr[31:ADDR_W+2], data_addr[1:0]};

   assign stall_if  = inst_req & ~inst_ready;
   assign stall_mem = data_req & ~data_ready;

   // ---------------------------------------------------------------------
   // Next-state and grant decision
   // ---------------------------------------------------------------------
   always_comb begin
      next_state  = state;
      grant_valid = 1'b0;
      grant_data  = 1'b0;
      access_done = 1'b0;
      case (state)
         IDLE: begin
            if (inst_req | data_req) begin
               grant_valid = 1'b1;
               // Data wins when alone, or on a tie when fetch was served last.
               grant_data  = data_req & (~inst_req | ~last_grant);
               next_state  = ACCESS;
            end
         end
         ACCESS: begin
            if (counter == 4'd0) begin
               access_done = 1'b1;
               next_state  = RESP;
            end
         end
         RESP: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   assign grant_addr = grant_data ? data_addr[ADDR_W+1:2] : inst_addr[ADDR_W+1:2];

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ---------------------------------------------------------------------
   // Access datapath: SRAM control registers, read capture, ready pulses
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         counter    <= 4'd0;
         owner      <= 1'b0;
         last_grant <= 1'b0;
         sram_cs    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= 32'd0;
         inst_rdata <= 32'd0;
         data_rdata <= 32'd0;
         inst_ready <= 1'b0;
         data_ready <= 1'b0;
      end else begin
         // Ready pulses are exactly the RESP cycle of the current owner.
         inst_ready <= access_done & ~owner;
         data_ready <= access_done & owner;

         if (grant_valid) begin
            owner      <= grant_data;
            last_grant <= grant_data;
            sram_cs    <= 1'b1;
            sram_we    <= grant_data & data_we;
            sram_addr  <= grant_addr;
            sram_wdata <= grant_data ? data_wdata : 32'd0;
            counter    <= CNT_LOAD;
         end else if (state == ACCESS) begin
            if (access_done) begin
               sram_cs <= 1'b0;
               sram_we <= 1'b0;
               // Stores leave the read-data registers untouched.
               if (!sram_we) begin
                  if (owner) begin
                     data_rdata <= sram_rdata;
                  end else begin
                     inst_rdata <= sram_rdata;
                  end
               end
            end else begin
               counter <= counter - 4'd1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Purpose  : Self-checking bench for sram_port_arbiter with a behavioural
//            SRAM model and an expected-response scoreboard queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_port_arbiter;

   localparam int ADDR_W = 11;
   localparam int AC     = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              inst_req = 1'b0;
   logic [31:0]       inst_addr = 32'd0;
   logic [31:0]       inst_rdata;
   logic              inst_ready;
   logic              data_req = 1'b0;
   logic              data_we = 1'b0;
   logic [31:0]       data_addr = 32'd0;
   logic [31:0]       data_wdata = 32'd0;
   logic [31:0]       data_rdata;
   logic              data_ready;
   logic              sram_cs;
   logic              sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [31:0]       sram_wdata;
   logic [31:0]       sram_rdata;
   logic              stall_if;
   logic              stall_mem;

   typedef struct packed {
      logic        is_data;
      logic [31:0] rdata;
      logic [7:0]  cyc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   sram_port_arbiter #(.ADDR_W(ADDR_W), .ACCESS_CYCLES(AC)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_rdata(inst_rdata), .inst_ready(inst_ready),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ready(data_ready),
      .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem)
   );

   always #5 clk = ~clk;

   assign sram_rdata = mem[sram_addr];
   always @(posedge clk) begin
      if (sram_cs && sram_we) mem[sram_addr] <= sram_wdata;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick();
      tick();
      total++; if (sram_cs !== 1'b0) begin bad++; $display("FAIL rst_cs: got %b want 0", sram_cs); end
      total++; if (sram_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", sram_we); end
      total++; if (sram_addr !== 11'd0) begin bad++; $display("FAIL rst_addr: got %h want 0", sram_addr); end
      total++; if (sram_wdata !== 32'd0) begin bad++; $display("FAIL rst_wdata: got %h want 0", sram_wdata); end
      total++; if (inst_rdata !== 32'd0 || data_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata: got %h/%h want 0/0", inst_rdata, data_rdata); end
      total++; if (inst_ready !== 1'b0 || data_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b/%b want 0/0", inst_ready, data_ready); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_single_load();
      exp_t e;
      mem[4] = 32'hDEADBEEF;
      data_we = 1'b0; data_addr = 32'h0000_0010; data_req = 1'b1;
      sb.push_back('{1'b1, 32'hDEADBEEF, 8'd3});
      #1;
      for (int c = 0; c <= 3; c++) begin
         total++; if (sram_cs !== (c == 1 || c == 2)) begin bad++; $display("FAIL sl_cs c%0d: got %b want %b", c, sram_cs, (c == 1 || c == 2)); end
         if (c == 1 || c == 2) begin
            total++; if (sram_addr !== 11'd4) begin bad++; $display("FAIL sl_addr c%0d: got %h want 4", c, sram_addr); end
         end
         total++; if (stall_mem !== (c <= 2)) begin bad++; $display("FAIL sl_stall c%0d: got %b want %b", c, stall_mem, (c <= 2)); end
         total++; if (data_ready !== (c == 3)) begin bad++; $display("FAIL sl_ready c%0d: got %b want %b", c, data_ready, (c == 3)); end
         if (data_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL sl_pop: ready with empty scoreboard"); end
            else begin
               e = sb.pop_front();
               if (data_rdata !== e.rdata || 8'(c) !== e.cyc) begin bad++; $display("FAIL sl_rdata: got %h@%0d want %h@%0d", data_rdata, c, e.rdata, e.cyc); end
            end
         end
         if (c == 3) data_req = 1'b0;
         tick();
      end
      total++; if (sram_cs !== 1'b0 || sb.size() != 0) begin bad++; $display("FAIL sl_end: cs=%b pending=%0d want 0/0", sram_cs, sb.size()); end
   endtask

   task automatic test_store_then_load();
      exp_t e;
      // Store: read-data register must still show the previous load value.
      data_we = 1'b1; data_addr = 32'h0000_0020; data_wdata = 32'h1234_5678; data_req = 1'b1;
      sb.push_back('{1'b1, 32'hDEADBEEF, 8'd3});
      #1;
      for (int c = 0; c <= 3; c++) begin
         total++; if (sram_we !== (c == 1 || c == 2)) begin bad++; $display("FAIL st_we c%0d: got %b want %b", c, sram_we, (c == 1 || c == 2)); end
         if (data_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL st_pop: ready with empty scoreboard"); end
            else begin
               e = sb.pop_front();
               if (data_rdata !== e.rdata || 8'(c) !== e.cyc) begin bad++; $display("FAIL st_rdata: got %h@%0d want %h@%0d", data_rdata, c, e.rdata, e.cyc); end
            end
         end
         if (c == 3) data_req = 1'b0;
         tick();
      end
      // Load back the stored word.
      data_we = 1'b0; data_req = 1'b1;
      sb.push_back('{1'b1, 32'h1234_5678, 8'd3});
      #1;
      for (int c = 0; c <= 3; c++) begin
         total++; if (sram_we !== 1'b0) begin bad++; $display("FAIL ld_we c%0d: got %b want 0", c, sram_we); end
         if (data_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL ld_pop: ready with empty scoreboard"); end
            else begin
               e = sb.pop_front();
               if (data_rdata !== e.rdata || 8'(c) !== e.cyc) begin bad++; $display("FAIL ld_rdata: got %h@%0d want %h@%0d", data_rdata, c, e.rdata, e.cyc); end
            end
         end
         if (c == 3) data_req = 1'b0;
         tick();
      end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL stld_end: pending=%0d want 0", sb.size()); end
   endtask

   task automatic test_both_from_reset();
      exp_t e;
      mem[2] = 32'hCAFE_0002;
      reset = 1'b0;
      inst_addr = 32'h0000_0008; inst_req = 1'b1;
      data_addr = 32'h0000_0010; data_we = 1'b0; data_req = 1'b1;
      tick();
      reset = 1'b1;
      sb.push_back('{1'b1, 32'hDEADBEEF, 8'd3});
      sb.push_back('{1'b0, 32'hCAFE_0002, 8'd7});
      sb.push_back('{1'b1, 32'hDEADBEEF, 8'd11});
      sb.push_back('{1'b0, 32'hCAFE_0002, 8'd15});
      for (int c = 1; c <= 15; c++) begin
         tick();
         total++; if (sram_cs !== ((c % 4) == 1 || (c % 4) == 2)) begin bad++; $display("FAIL bt_cs c%0d: got %b", c, sram_cs); end
         total++; if (stall_if !== (c != 7 && c != 15) || stall_mem !== (c != 3 && c != 11)) begin bad++; $display("FAIL bt_stall c%0d: got if=%b mem=%b", c, stall_if, stall_mem); end
         if (inst_ready === 1'b1 && data_ready === 1'b1) begin
            total++; bad++; $display("FAIL bt_both_ready c%0d: got 1/1 want at most one", c);
         end else if (inst_ready === 1'b1 || data_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL bt_pop c%0d: ready with empty scoreboard", c); end
            else begin
               e = sb.pop_front();
               if (data_ready !== e.is_data || 8'(c) !== e.cyc ||
                   (e.is_data ? data_rdata : inst_rdata) !== e.rdata) begin
                  bad++;
                  $display("FAIL bt_order c%0d: got data=%b rdata=%h want data=%b rdata=%h at %0d",
                           c, data_ready, (data_ready ? data_rdata : inst_rdata), e.is_data, e.rdata, e.cyc);
               end
            end
         end
         if (c == 15) begin inst_req = 1'b0; data_req = 1'b0; end
      end
      tick();
      total++; if (sram_cs !== 1'b0 || sb.size() != 0) begin bad++; $display("FAIL bt_end: cs=%b pending=%0d want 0/0", sram_cs, sb.size()); sb.delete(); end
   endtask

   task automatic test_addr_wrap();
      exp_t e;
      mem[1] = 32'h1111_0001;
      data_we = 1'b0; data_addr = 32'h0000_2004; data_req = 1'b1;
      sb.push_back('{1'b1, 32'h1111_0001, 8'd3});
      #1;
      for (int c = 0; c <= 3; c++) begin
         if (c == 1) begin
            total++; if (sram_cs !== 1'b1 || sram_addr !== 11'd1) begin bad++; $display("FAIL wr_addr: got cs=%b addr=%h want 1/001", sram_cs, sram_addr); end
         end
         if (data_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL wr_pop: ready with empty scoreboard"); end
            else begin
               e = sb.pop_front();
               if (data_rdata !== e.rdata || 8'(c) !== e.cyc) begin bad++; $display("FAIL wr_rdata: got %h@%0d want %h@%0d", data_rdata, c, e.rdata, e.cyc); end
            end
         end
         if (c == 3) data_req = 1'b0;
         tick();
      end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL wr_end: pending=%0d want 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_reset_mid_access();
      exp_t e;
      mem[3] = 32'hA5A5_0003;
      inst_addr = 32'h0000_000C; inst_req = 1'b1;
      sb.push_back('{1'b0, 32'hA5A5_0003, 8'd3});
      tick();
      total++; if (sram_cs !== 1'b1) begin bad++; $display("FAIL rm_cs1: got %b want 1", sram_cs); end
      #1 reset = 1'b0;
      #1;
      total++; if (sram_cs !== 1'b0 || inst_ready !== 1'b0) begin bad++; $display("FAIL rm_abort: got cs=%b ready=%b want 0/0", sram_cs, inst_ready); end
      tick();
      total++; if (sram_cs !== 1'b0 || inst_ready !== 1'b0 || stall_if !== 1'b1) begin bad++; $display("FAIL rm_hold: got cs=%b ready=%b stall=%b want 0/0/1", sram_cs, inst_ready, stall_if); end
      reset = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         tick();
         total++; if (sram_cs !== (c <= 2)) begin bad++; $display("FAIL rm_recs c%0d: got %b want %b", c, sram_cs, (c <= 2)); end
         total++; if (inst_ready !== (c == 3) || stall_if !== (c <= 2)) begin bad++; $display("FAIL rm_ready c%0d: got ready=%b stall=%b", c, inst_ready, stall_if); end
         if (inst_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL rm_pop: ready with empty scoreboard"); end
            else begin
               e = sb.pop_front();
               if (inst_rdata !== e.rdata || 8'(c) !== e.cyc) begin bad++; $display("FAIL rm_rdata: got %h@%0d want %h@%0d", inst_rdata, c, e.rdata, e.cyc); end
            end
         end
         if (c == 3) inst_req = 1'b0;
      end
      tick();
      total++; if (sb.size() != 0) begin bad++; $display("FAIL rm_end: pending=%0d want 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_request_withdrawn();
      exp_t e;
      data_we = 1'b0; data_addr = 32'h0000_0010; data_req = 1'b1;
      sb.push_back('{1'b1, 32'hDEADBEEF, 8'd3});
      #1;
      total++; if (stall_mem !== 1'b1) begin bad++; $display("FAIL wd_stall0: got %b want 1", stall_mem); end
      tick();
      data_req = 1'b0;
      #1;
      for (int c = 1; c <= 5; c++) begin
         total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL wd_stall c%0d: got %b want 0", c, stall_mem); end
         total++; if (data_ready !== (c == 3) || sram_cs !== (c <= 2)) begin bad++; $display("FAIL wd_seq c%0d: got ready=%b cs=%b", c, data_ready, sram_cs); end
         if (data_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL wd_pop: ready with empty scoreboard"); end
            else begin
               e = sb.pop_front();
               if (data_rdata !== e.rdata || 8'(c) !== e.cyc) begin bad++; $display("FAIL wd_rdata: got %h@%0d want %h@%0d", data_rdata, c, e.rdata, e.cyc); end
            end
         end
         tick();
      end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL wd_end: pending=%0d want 0", sb.size()); sb.delete(); end
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'd0;
      test_reset();
      test_single_load();
      test_store_then_load();
      test_both_from_reset();
      test_addr_wrap();
      test_reset_mid_access();
      test_request_withdrawn();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
